// File: rtl/sample0_dot_pkg.sv
// Types and helpers shared by the sample0 neuron datapath stages: the tag that travels
// beside the multiplier pipeline, and the ReLU/saturation step applied to finished sums.
package sample0_dot_pkg;

  localparam int TAG_BIAS_W = 11;

  typedef struct packed {
    logic                  vld;
    logic                  first;
    logic                  last;
    logic [TAG_BIAS_W-1:0] bias;
  } tag_t;

  typedef struct packed {
    logic               sat;
    logic signed [31:0] val;
  } res_t;

  // Optional ReLU, then clamp into a dout_w-bit signed range; sat flags a clip.
  function automatic res_t relu_sat(input logic signed [31:0] sum,
                                    input int                 dout_w,
                                    input logic               relu);
    logic signed [31:0] r;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    res_t               res;
    r       = (relu && (sum < 0)) ? '0 : sum;
    hi      = (32'sd1 <<< (dout_w - 1)) - 32'sd1;
    lo      = -(32'sd1 <<< (dout_w - 1));
    res.sat = (r > hi) || (r < lo);
    res.val = (r > hi) ? hi : ((r < lo) ? lo : r);
    return res;
  endfunction

endpackage

// File: rtl/sample0_dot_tagpipe.sv
// Enabled shift register that carries one tag per multiplier slot, so each product
// emerges together with its valid, first/last flags and bias.
module sample0_dot_tagpipe
  import sample0_dot_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  tag_t din,
  output tag_t dout
);

  tag_t stage [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: every stage is reset, not just vld, so an aborted vector leaves no stale tag behind.
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (en) begin
      // NOTE: non-blocking, so each stage takes its neighbour's pre-edge value and the chain shifts by one.
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/sample0_dot_acc.sv
// Dot-product accumulator behind the pipelined sample0 multiplier: sums LEN products plus a
// per-vector bias, applies optional ReLU and saturation, and emits on valid/ready with full stall.
module sample0_dot_acc
  import sample0_dot_pkg::*;
#(
  parameter int LEN     = 4,
  parameter int DIN_W   = 11,
  parameter int ACC_W   = 16,
  parameter int DOUT_W  = 11,
  parameter int RELU    = 0,
  parameter int MUL_LAT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DIN_W-1:0]  in_a,
  input  logic signed [DIN_W-1:0]  in_b,
  input  logic signed [DIN_W-1:0]  in_bias,
  output logic                     mul_ce,
  output logic signed [DIN_W-1:0]  mul_din0,
  output logic signed [DIN_W-1:0]  mul_din1,
  input  logic signed [DIN_W-1:0]  mul_dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DOUT_W-1:0] out_data,
  output logic                     out_sat
);

  localparam int               CNT_W    = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  logic                    stall;
  logic                    accept;
  logic                    first;
  logic                    last;
  logic [CNT_W-1:0]        term_cnt;
  tag_t                    tag_in;
  tag_t                    tag_out;
  logic                    acc_en;
  logic                    res_en;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  res_t                    res;

  // A held result freezes everything upstream, including the external multiplier.
  assign stall    = out_valid && !out_ready;
  assign mul_ce   = !stall;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  assign first    = (term_cnt == '0);
  assign last     = (term_cnt == CNT_LAST);
  assign mul_din0 = in_a;
  assign mul_din1 = in_b;

  assign tag_in = '{vld: accept, first: first, last: last, bias: TAG_BIAS_W'(in_bias)};

  sample0_dot_tagpipe #(
    .DEPTH (MUL_LAT)
  ) u_tagpipe (
    .clk   (clk),
    .reset (reset),
    .en    (mul_ce),
    .din   (tag_in),
    .dout  (tag_out)
  );

  // mul_dout is garbage unless the matching tag is valid, so both enables gate on vld.
  assign acc_en = mul_ce && tag_out.vld;
  assign res_en = acc_en && tag_out.last;

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
    acc_next = acc + ACC_W'(mul_dout);
    if (tag_out.first) acc_next = ACC_W'($signed(tag_out.bias)) + ACC_W'(mul_dout);
    res = relu_sat(32'(acc_next), DOUT_W, RELU != 0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      term_cnt  <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (accept) term_cnt <= last ? '0 : term_cnt + 1'b1;
      if (acc_en) acc <= acc_next;
      // A load only happens when not stalled, so it may safely replace a result being consumed.
      if (res_en) begin
        out_valid <= 1'b1;
        out_data  <= res.val[DOUT_W-1:0];
        out_sat   <= res.sat;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample0_dot_acc.sv
// Bench for sample0_dot_acc: three instances (LEN=4, LEN=4 with ReLU, LEN=1), each behind a
// behavioural 2-stage truncating multiplier, checked against a plain-arithmetic dot-product model.
module tb_sample0_dot_acc;

  localparam int DIN_W   = 11;
  localparam int ACC_W   = 16;
  localparam int DOUT_W  = 11;
  localparam int MUL_LAT = 2;
  localparam int NDUT    = 3;

  typedef struct {
    int sel;
    int data;
    bit sat;
    int cyc;
  } obs_t;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     ordy;
  logic signed [DIN_W-1:0]  a;
  logic signed [DIN_W-1:0]  b;
  logic signed [DIN_W-1:0]  bias;
  logic                     iv   [NDUT];
  logic                     ird  [NDUT];
  logic                     mce  [NDUT];
  logic                     ov   [NDUT];
  logic                     os   [NDUT];
  logic signed [DIN_W-1:0]  md0  [NDUT];
  logic signed [DIN_W-1:0]  md1  [NDUT];
  logic signed [DIN_W-1:0]  mdo  [NDUT];
  logic signed [DOUT_W-1:0] od   [NDUT];

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   done;
  obs_t got [$];
  int   acq [$];
  int   va [$];
  int   vb [$];
  int   vbias [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic signed [DIN_W-1:0] p1;
    logic signed [DIN_W-1:0] p2;

    sample0_dot_acc #(
      .LEN     ((g == 2) ? 1 : 4),
      .DIN_W   (DIN_W),
      .ACC_W   (ACC_W),
      .DOUT_W  (DOUT_W),
      .RELU    ((g == 1) ? 1 : 0),
      .MUL_LAT (MUL_LAT)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (iv[g]),
      .in_ready  (ird[g]),
      .in_a      (a),
      .in_b      (b),
      .in_bias   (bias),
      .mul_ce    (mce[g]),
      .mul_din0  (md0[g]),
      .mul_din1  (md1[g]),
      .mul_dout  (mdo[g]),
      .out_valid (ov[g]),
      .out_ready (ordy),
      .out_data  (od[g]),
      .out_sat   (os[g])
    );

    // External multiplier: two ce-enabled stages, no reset, product truncated to DIN_W bits.
    always @(posedge clk) begin
      if (mce[g]) begin
        p1 <= DIN_W'(md0[g] * md1[g]);
        p2 <= p1;
      end
    end
    assign mdo[g] = p2;
  end

  // Monitor: records accepted beats and consumed results, sampled mid-cycle.
  always @(negedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      if (!reset && iv[g] && ird[g]) acq.push_back(cyc);
      if (!reset && ov[g] && ordy) got.push_back('{g, int'(od[g]), os[g], cyc});
    end
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic int trunc_din(input int x);
    int t;
    t = x & ((1 << DIN_W) - 1);
    if (t >= (1 << (DIN_W - 1))) t -= (1 << DIN_W);
    return t;
  endfunction

  function automatic int len_of(input int g);
    return (g == 2) ? 1 : 4;
  endfunction

  // Reference: bias + sum of truncated products, then ReLU (instance 1) and 11-bit clamp.
  function automatic void ref_dot(input int g, input int v, output int data, output bit sat);
    int s;
    int len;
    len = len_of(g);
    s   = vbias[v];
    for (int i = 0; i < len; i++) s += trunc_din(va[v*len+i] * vb[v*len+i]);
    if (g == 1 && s < 0) s = 0;
    sat = 1'b0;
    if (s > 1023) begin
      s = 1023;
      sat = 1'b1;
    end else if (s < -1024) begin
      s = -1024;
      sat = 1'b1;
    end
    data = s;
  endfunction

  function automatic int rnd_din();
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  task automatic clear_q();
    got.delete();
    acq.delete();
    va.delete();
    vb.delete();
    vbias.delete();
  endtask

  task automatic send_beat(input int sel, input int x, input int y, input int bv);
    int n;
    @(posedge clk);
    #1;
    iv[sel] = 1'b1;
    a       = DIN_W'(x);
    b       = DIN_W'(y);
    bias    = DIN_W'(bv);
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ird[sel]) break;
      @(posedge clk);
      #1;
    end
    if (n == 200) begin
      tests++;
      fails++;
      $display("FAIL beat_timeout: in_ready of dut %0d stayed 0 for 200 cycles, required 1", sel);
    end
  endtask

  // Streams every beat in va/vb; bias is meaningful only on vector starts, random elsewhere.
  task automatic send_stream(input int sel);
    int len;
    int bv;
    len = len_of(sel);
    for (int i = 0; i < va.size(); i++) begin
      bv = ((i % len) == 0) ? vbias[i/len] : rnd_din();
      send_beat(sel, va[i], vb[i], bv);
    end
    @(posedge clk);
    #1;
    iv[sel] = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    for (int k = 0; k < budget && got.size() < n; k++) @(posedge clk);
    if (got.size() < n) begin
      tests++;
      fails++;
      $display("FAIL result_timeout: %0d results after %0d cycles, required %0d", got.size(), budget, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int pass = 0; pass < 2; pass++) begin
      for (int g = 0; g < NDUT; g++) begin
        tests += 5;
        if (ov[g] !== 1'b0) begin fails++; $display("FAIL reset_out_valid[%0d] pass %0d: got %b, expected 0", g, pass, ov[g]); end
        if (od[g] !== '0) begin fails++; $display("FAIL reset_out_data[%0d] pass %0d: got %0d, expected 0", g, pass, od[g]); end
        if (os[g] !== 1'b0) begin fails++; $display("FAIL reset_out_sat[%0d] pass %0d: got %b, expected 0", g, pass, os[g]); end
        if (mce[g] !== 1'b1) begin fails++; $display("FAIL reset_mul_ce[%0d] pass %0d: got %b, expected 1", g, pass, mce[g]); end
        if (ird[g] !== 1'b1) begin fails++; $display("FAIL reset_in_ready[%0d] pass %0d: got %b, expected 1", g, pass, ird[g]); end
      end
      if (pass == 0) begin
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
      end
    end
  endtask

  task automatic test_basic();
    clear_q();
    va = '{1, 2, 3, 4};
    vb = '{5, 6, 7, 8};
    vbias = '{10};
    send_stream(0);
    wait_results(1, 50);
    if (got.size() >= 1 && acq.size() == 4) begin
      tests += 3;
      if (got[0].data !== 80) begin fails++; $display("FAIL basic_data: got %0d, expected 80", got[0].data); end
      if (got[0].sat !== 1'b0) begin fails++; $display("FAIL basic_sat: got %b, expected 0", got[0].sat); end
      if (got[0].cyc - acq[3] !== MUL_LAT + 1) begin
        fails++;
        $display("FAIL basic_latency: got %0d cycles, expected %0d", got[0].cyc - acq[3], MUL_LAT + 1);
      end
    end
  endtask

  task automatic load_two_vectors();
    clear_q();
    va = '{1, 1, 1, 1, 2, 2, 2, 2};
    vb = '{1, 1, 1, 1, 3, 3, 3, 3};
    vbias = '{0, -5};
  endtask

  task automatic test_back_to_back();
    load_two_vectors();
    send_stream(0);
    wait_results(2, 60);
    tests++;
    if (acq.size() !== 8 || acq[7] - acq[0] !== 7) begin
      fails++;
      $display("FAIL b2b_beats: %0d beats over %0d cycles, expected 8 over 7", acq.size(), acq[acq.size()-1] - acq[0]);
    end
    if (got.size() >= 2) begin
      tests += 3;
      if (got[0].data !== 4) begin fails++; $display("FAIL b2b_first: got %0d, expected 4", got[0].data); end
      if (got[1].data !== 19) begin fails++; $display("FAIL b2b_second: got %0d, expected 19", got[1].data); end
      if (got[1].cyc - got[0].cyc !== 4) begin
        fails++;
        $display("FAIL b2b_spacing: got %0d cycles, expected 4", got[1].cyc - got[0].cyc);
      end
    end
  endtask

  task automatic test_stall();
    int k;
    load_two_vectors();
    fork
      send_stream(0);
      begin
        for (k = 0; k < 100; k++) begin
          @(posedge clk);
          #1;
          if (ov[0]) break;
        end
        tests++;
        if (k == 100) begin fails++; $display("FAIL stall_no_result: out_valid never rose, expected 1"); end
        ordy = 1'b0;
        repeat (5) begin
          @(negedge clk);
          tests += 2;
          if (mce[0] !== 1'b0) begin fails++; $display("FAIL stall_mul_ce: got %b, expected 0", mce[0]); end
          if (ird[0] !== 1'b0) begin fails++; $display("FAIL stall_in_ready: got %b, expected 0", ird[0]); end
        end
        @(posedge clk);
        #1;
        ordy = 1'b1;
      end
    join
    wait_results(2, 60);
    tests++;
    if (acq.size() !== 8) begin fails++; $display("FAIL stall_beats: got %0d beats, expected 8", acq.size()); end
    if (got.size() >= 2) begin
      tests += 2;
      if (got[0].data !== 4) begin fails++; $display("FAIL stall_first: got %0d, expected 4", got[0].data); end
      if (got[1].data !== 19) begin fails++; $display("FAIL stall_second: got %0d, expected 19", got[1].data); end
    end
  endtask

  task automatic test_saturation();
    int exp_d [2][2];
    bit exp_s [2][2];
    exp_d = '{'{1023, -1024}, '{1023, 0}};
    exp_s = '{'{1'b1, 1'b1}, '{1'b1, 1'b0}};
    for (int g = 0; g < 2; g++) begin
      clear_q();
      va = '{31, 31, 31, 31, -31, -31, -31, -31};
      vb = '{31, 31, 31, 31, 31, 31, 31, 31};
      vbias = '{0, 0};
      send_stream(g);
      wait_results(2, 60);
      for (int i = 0; i < 2 && i < got.size(); i++) begin
        tests += 2;
        if (got[i].data !== exp_d[g][i]) begin
          fails++;
          $display("FAIL sat_data dut%0d vec%0d: got %0d, expected %0d", g, i, got[i].data, exp_d[g][i]);
        end
        if (got[i].sat !== exp_s[g][i]) begin
          fails++;
          $display("FAIL sat_flag dut%0d vec%0d: got %b, expected %b", g, i, got[i].sat, exp_s[g][i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    send_beat(0, 7, 9, 100);
    send_beat(0, 5, 5, 0);
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (ov[0] !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid: got %b, expected 0", ov[0]); end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_q();
    va = '{1, 1, 1, 1};
    vb = '{2, 2, 2, 2};
    vbias = '{1};
    send_stream(0);
    wait_results(1, 50);
    repeat (10) @(posedge clk);
    tests++;
    if (got.size() !== 1) begin fails++; $display("FAIL rstmid_count: got %0d results, expected 1", got.size()); end
    if (got.size() >= 1) begin
      tests++;
      if (got[0].data !== 9) begin fails++; $display("FAIL rstmid_data: got %0d, expected 9", got[0].data); end
    end
  endtask

  task automatic test_len1();
    int ed;
    bit es;
    clear_q();
    va = '{-3};
    vb = '{4};
    vbias = '{2};
    send_stream(2);
    wait_results(1, 50);
    if (got.size() >= 1 && acq.size() == 1) begin
      tests += 2;
      if (got[0].data !== -10) begin fails++; $display("FAIL len1_data: got %0d, expected -10", got[0].data); end
      if (got[0].cyc - acq[0] !== MUL_LAT + 1) begin
        fails++;
        $display("FAIL len1_latency: got %0d cycles, expected %0d", got[0].cyc - acq[0], MUL_LAT + 1);
      end
    end
    clear_q();
    for (int i = 0; i < 8; i++) begin
      va.push_back(rnd_din());
      vb.push_back(rnd_din());
      vbias.push_back(rnd_din());
    end
    send_stream(2);
    wait_results(8, 50);
    for (int i = 0; i < got.size() && i < 8; i++) begin
      ref_dot(2, i, ed, es);
      tests += 2;
      if (got[i].data !== ed || got[i].sat !== es) begin
        fails++;
        $display("FAIL len1_stream[%0d]: got %0d/%b, expected %0d/%b", i, got[i].data, got[i].sat, ed, es);
      end
      if (i > 0 && got[i].cyc - got[i-1].cyc !== 1) begin
        fails++;
        $display("FAIL len1_rate[%0d]: got spacing %0d, expected 1", i, got[i].cyc - got[i-1].cyc);
      end
    end
  endtask

  task automatic test_random();
    int ed;
    bit es;
    int nvec;
    for (int g = 0; g < NDUT; g++) begin
      clear_q();
      nvec = 10;
      for (int i = 0; i < nvec * len_of(g); i++) begin
        va.push_back(rnd_din());
        vb.push_back(rnd_din());
      end
      for (int v = 0; v < nvec; v++) vbias.push_back(rnd_din());
      done = 1'b0;
      fork
        begin
          send_stream(g);
          done = 1'b1;
        end
        while (!done) begin
          @(posedge clk);
          #1;
          ordy = ($urandom_range(0, 2) != 0);
        end
      join
      ordy = 1'b1;
      wait_results(nvec, 200);
      tests++;
      if (got.size() !== nvec) begin fails++; $display("FAIL rand_count dut%0d: got %0d, expected %0d", g, got.size(), nvec); end
      for (int v = 0; v < got.size() && v < nvec; v++) begin
        ref_dot(g, v, ed, es);
        tests++;
        if (got[v].sel !== g || got[v].data !== ed || got[v].sat !== es) begin
          fails++;
          $display("FAIL rand dut%0d vec%0d: got dut%0d %0d/%b, expected %0d/%b",
                   g, v, got[v].sel, got[v].data, got[v].sat, ed, es);
        end
      end
    end
  endtask

  initial begin
    foreach (iv[i]) iv[i] = 1'b0;
    ordy = 1'b1;
    a    = '0;
    b    = '0;
    bias = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_saturation();
    test_reset_mid();
    test_len1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
